// File: rtl/gray_ptr_fifo8.sv
// gray_ptr_fifo8: 8-entry single-clock sample FIFO addressed by Gray pointers.
// Ports: clk/rst (sync, active-high), wr_en/wr_data, rd_en -> rd_data/rd_valid,
//        full/empty/count occupancy, wr/rd Gray pointers, sticky overflow/underflow.
module gray_ptr_fifo8 #(
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [3:0]        count,
  output logic [2:0]        wr_ptr_gray,
  output logic [2:0]        rd_ptr_gray,
  output logic              overflow,
  output logic              underflow
);

  // One-bit-change successor in the Gray ring.
  function automatic logic [2:0] f_gray_next(
    input logic [2:0] g
  );
    logic [2:0] n;
    case (g)
      3'b000:  n = 3'b001;
      3'b001:  n = 3'b011;
      3'b011:  n = 3'b010;
      3'b010:  n = 3'b110;
      3'b110:  n = 3'b111;
      3'b111:  n = 3'b101;
      3'b101:  n = 3'b100;
      default: n = 3'b000;
    endcase
    return n;
  endfunction

  logic [DATA_W-1:0] r_mem [8];
  logic [2:0]        r_wr_ptr;
  logic [2:0]        r_rd_ptr;
  logic              r_wr_wrap;
  logic              r_rd_wrap;
  logic [3:0]        r_count;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_ovf;
  logic              r_unf;

  logic              w_ptr_eq;
  logic              w_full;
  logic              w_empty;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [2:0]        w_wr_nxt;
  logic [2:0]        w_rd_nxt;

  // Flags come only from registered pointers and wrap bits.
  assign w_ptr_eq = (r_wr_ptr == r_rd_ptr);
  assign w_empty  = w_ptr_eq & (r_wr_wrap == r_rd_wrap);
  assign w_full   = w_ptr_eq & (r_wr_wrap != r_rd_wrap);

  // At full only the read can go; at empty only the write can go.
  assign w_wr_acc = wr_en & ~w_full;
  assign w_rd_acc = rd_en & ~w_empty;

  assign w_wr_nxt = f_gray_next(r_wr_ptr);
  assign w_rd_nxt = f_gray_next(r_rd_ptr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= 3'b000;
      r_wr_wrap <= 1'b0;
    end else if (w_wr_acc) begin
      r_wr_ptr <= w_wr_nxt;
      if (r_wr_ptr == 3'b100)
        r_wr_wrap <= ~r_wr_wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr  <= 3'b000;
      r_rd_wrap <= 1'b0;
    end else if (w_rd_acc) begin
      r_rd_ptr <= w_rd_nxt;
      if (r_rd_ptr == 3'b100)
        r_rd_wrap <= ~r_rd_wrap;
    end
  end

  // Storage is left unreset; the Gray code is used directly as the address.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_acc)
      r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc)
        r_rd_data <= r_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 4'd0;
    end else begin
      unique case (1'b1)
        (w_wr_acc & ~w_rd_acc): r_count <= r_count + 4'd1;
        (w_rd_acc & ~w_wr_acc): r_count <= r_count - 4'd1;
        default:                r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags; a request against the blocking flag is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (wr_en && w_full)
        r_ovf <= 1'b1;
      if (rd_en && w_empty)
        r_unf <= 1'b1;
    end
  end

  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;
  assign full        = w_full;
  assign empty       = w_empty;
  assign count       = r_count;
  assign wr_ptr_gray = r_wr_ptr;
  assign rd_ptr_gray = r_rd_ptr;
  assign overflow    = r_ovf;
  assign underflow   = r_unf;

endmodule

// File: tb/tb_gray_ptr_fifo8.sv
// tb_gray_ptr_fifo8: scoreboard bench for gray_ptr_fifo8.
// A queue model predicts state; a monitor checks each rd_valid word.
module tb_gray_ptr_fifo8;

  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic [3:0]    count;
  logic [2:0]    wr_ptr_gray;
  logic [2:0]    rd_ptr_gray;
  logic          overflow;
  logic          underflow;

  int total = 0;
  int bad   = 0;

  // Reference model
  logic [DW-1:0] mq [$];
  logic [DW-1:0] exp_q [$];
  int            widx;
  int            ridx;
  logic          e_ovf;
  logic          e_unf;
  logic          e_rv;
  logic [DW-1:0] e_rd;

  gray_ptr_fifo8 #(.DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .wr_ptr_gray (wr_ptr_gray),
    .rd_ptr_gray (rd_ptr_gray),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] bin2gray(input int b);
    logic [2:0] x;
    x = 3'(b % 8);
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Read-data monitor: every rd_valid must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected: got %0h expected none", rd_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          bad++;
          $display("FAIL rd_data: got %0h expected %0h", rd_data, e);
        end
      end
    end
  end

  // Gray monitor: at most one pointer bit may change per non-reset edge.
  always @(posedge clk) begin
    logic [2:0] pw;
    logic [2:0] pr;
    logic       prs;
    pw  = wr_ptr_gray;
    pr  = rd_ptr_gray;
    prs = rst;
    #1;
    if (prs === 1'b0) begin
      chk("wr_gray_step", $countones(pw ^ wr_ptr_gray) <= 1, 1);
      chk("rd_gray_step", $countones(pr ^ rd_ptr_gray) <= 1, 1);
    end
  end

  task automatic step(
    input logic          w,
    input logic [DW-1:0] d,
    input logic          r,
    input logic          rs
  );
    int  sz;
    logic wa;
    logic ra;
    @(negedge clk);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    rst     = rs;
    sz = mq.size();
    if (rs) begin
      mq.delete();
      widx  = 0;
      ridx  = 0;
      e_ovf = 1'b0;
      e_unf = 1'b0;
      e_rv  = 1'b0;
      e_rd  = '0;
    end else begin
      wa = w && (sz < 8);
      ra = r && (sz > 0);
      if (w && sz == 8) e_ovf = 1'b1;
      if (r && sz == 0) e_unf = 1'b1;
      e_rv = ra;
      if (ra) begin
        e_rd = mq.pop_front();
        exp_q.push_back(e_rd);
        ridx++;
      end
      if (wa) begin
        mq.push_back(d);
        widx++;
      end
    end
    @(posedge clk);
    #1;
    chk("count", int'(count), mq.size());
    chk("full", int'(full), int'(mq.size() == 8));
    chk("empty", int'(empty), int'(mq.size() == 0));
    chk("overflow", int'(overflow), int'(e_ovf));
    chk("underflow", int'(underflow), int'(e_unf));
    chk("rd_valid", int'(rd_valid), int'(e_rv));
    chk("rd_data_hold", int'(rd_data), int'(e_rd));
    chk("wr_ptr_gray", int'(wr_ptr_gray), int'(bin2gray(widx)));
    chk("rd_ptr_gray", int'(rd_ptr_gray), int'(bin2gray(ridx)));
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    widx    = 0;
    ridx    = 0;
    e_ovf   = 1'b0;
    e_unf   = 1'b0;
    e_rv    = 1'b0;
    e_rd    = '0;

    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // Fill 1..8 then overflow on a ninth write
    for (int i = 1; i <= 8; i++)
      step(1, DW'(i), 0, 0);
    chk("fill_full", int'(full), 1);
    step(1, 10'h3ff, 0, 0);
    chk("fill_ovf", int'(overflow), 1);

    // Drain in order, then underflow
    for (int i = 0; i < 8; i++)
      step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("drain_unf", int'(underflow), 1);
    chk("drain_rv0", int'(rd_valid), 0);

    // Simultaneous access with three entries held
    step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      step(1, DW'($urandom), 0, 0);
    for (int i = 0; i < 10; i++)
      step(1, DW'($urandom), 1, 0);
    chk("simul_count", int'(count), 3);

    // Full with both requests
    for (int i = 0; i < 5; i++)
      step(1, DW'($urandom), 0, 0);
    step(1, 10'h155, 1, 0);
    chk("full_both_count", int'(count), 7);

    // Both requests while empty
    step(0, 0, 0, 1);
    step(1, 10'h2aa, 1, 0);
    chk("empty_both_unf", int'(underflow), 1);

    // Reset mid-operation alongside a write
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++)
      step(1, DW'($urandom), 0, 0);
    step(1, 10'h0ff, 0, 1);
    chk("rst_mid_ptr", int'(wr_ptr_gray), 0);
    step(0, 0, 0, 0);

    // Random traffic with rare resets
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1), DW'($urandom), $urandom_range(0, 1),
           ($urandom_range(0, 99) == 0));

    step(0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
